vga_sync_timing: RTL and testbench
==================================

Name: vga_sync_timing

Overview:
Raster timing generator upstream of the pixel/colour stage. Generates free-running horizontal and vertical counters and exports them as pixel coordinates for downstream colour logic. Accepts the colour that logic computes and re-aligns it with HSync/VSync through a matched delay line. Blanks colour outside the active area and drives the 3-bit-per-channel VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks); H_TOTAL = sum = 800
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = sum = 525
SYNC_POL, 0, asserted sync pin level (0 = active-low)
PIPE_DELAY, 2, clocks from o_X/o_Y to matching i_Red/i_Grn/i_Blu arrival; legal range 0..7

Ports:
i_Clk  in  1  pixel clock, 25 MHz
w_Reset  in  1  synchronous, active-high reset
o_X  out  12  horizontal counter, 0..H_TOTAL-1
o_Y  out  12  vertical counter, 0..V_TOTAL-1
o_Active  out  1  high when o_X<H_ACTIVE and o_Y<V_ACTIVE
o_Line_Start  out  1  one-clock pulse when o_X==0
o_Frame_Start  out  1  one-clock pulse when o_X==0 and o_Y==0
i_Red  in  3  colour for the coordinate issued PIPE_DELAY clocks earlier
i_Grn  in  3  same, green
i_Blu  in  3  same, blue
o_VGA_HSync  out  1  horizontal sync pin
o_VGA_VSync  out  1  vertical sync pin
o_VGA_Red  out  3  red pin, blanked
o_VGA_Grn  out  3  green pin, blanked
o_VGA_Blu  out  3  blue pin, blanked

Behaviour:
- Reset: clock i_Clk, reset w_Reset, synchronous, active-high.
- While w_Reset is high, on each clock edge:
  - h_cnt and v_cnt load 0.
  - All delay-line stages clear to inactive (active=0, sync deasserted).
  - Colour pins output 0.
  - Sync pins output ~SYNC_POL.
- Reset is checked before every other action and takes priority in any cycle.
- Counters:
  - h_cnt increments every clock; at H_TOTAL-1 it wraps to 0.
  - v_cnt increments only on the h_cnt wrap; at V_TOTAL-1 (with h wrap) it wraps to 0.
  - o_X and o_Y are the registered counters, including blanking values.
  - o_Active, o_Line_Start and o_Frame_Start decode from the registered counters (same-cycle as o_X/o_Y).
  - o_Frame_Start pulses in the first clock after reset release, since the counters are at (0,0).
- Raw sync:
  - hs_raw = (H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
  - vs_raw = (V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC), i.e. 490..491, whole lines.
- Alignment:
  - {active, hs_raw, vs_raw} pass through a PIPE_DELAY-deep shift register, then one output register.
  - Colour inputs are sampled once, in the same output register.
  - Pin state for coordinate (x,y) appears PIPE_DELAY+1 clocks after o_X/o_Y show (x,y).
- Blanking:
  - Output colour = delayed_active ? input colour : 0. No saturation or arithmetic on colour.
- Sync pin level:
  - Asserted level is SYNC_POL when delayed sync is 1; otherwise ~SYNC_POL.
- Reset mid-frame:
  - Counters restart at (0,0).
  - For PIPE_DELAY+1 clocks after release, pins stay blanked with sync idle; the first frame follows with no partial line.
- Width rule:
  - Counter comparisons are 12-bit unsigned.
  - Parameters must give H_TOTAL and V_TOTAL <= 4095 (elaboration check).

Decomposition:
- Shared package vga_timing_pkg holds:
  - 640x480@60 timing constants (the parameter defaults above).
  - COLOUR_W=3 and COORD_W=12.
  - The derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START and VS_END expressions.
- One sub-module, vga_delay_line (params WIDTH, DEPTH; DEPTH=0 is a wire), carries {active, hs, vs}.
- Counters and output register stay in vga_sync_timing.

Test Plan:
- Release w_Reset -> o_X counts 0..799 and wraps with o_Y+1; o_Frame_Start high exactly 1 clock at (0,0); frame period 420000 clocks.
- HSync (SYNC_POL=0, PIPE_DELAY=2) -> o_VGA_HSync goes low 3 clocks after o_X==656, stays low 96 clocks, repeats every 800 clocks.
- VSync -> o_VGA_VSync goes low 3 clocks after (x=0,y=490), stays low exactly 1600 clocks.
- Colour gating: hold i_Red=7, i_Grn=3, i_Blu=5 -> pins show 7/3/5 for exactly 640 clocks per line on 480 lines, 0 elsewhere; first non-zero pixel 3 clocks after (0,0).
- Mid-frame reset: pulse w_Reset at (300,200) -> next clock o_X=0, o_Y=0; pins 0 with sync high for 3 clocks; o_Frame_Start on release.
- PIPE_DELAY=0 build -> colour for (x,y) driven on i_Red the same clock appears on pins 1 clock later; hsync low 1 clock after o_X==656.

Source files
------------

// File: rtl/vga_sync_timing_pkg.sv
// Shared 640x480@60 raster constants and types for the
// VGA timing slice.
package vga_timing_pkg;

    localparam int COORD_W  = 12;
    localparam int COLOUR_W = 3;
    localparam int MAX_PIPE = 7;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL =
        DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL =
        DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int HS_END   = HS_START + DEF_H_SYNC;
    localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int VS_END   = VS_START + DEF_V_SYNC;

    typedef logic [COORD_W-1:0]  coord_t;
    typedef logic [COLOUR_W-1:0] colour_t;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } sync_t;

endpackage

// File: rtl/vga_sync_timing_if.sv
// Pixel-side bus: coordinates out to the colour logic,
// colour back in from it.
interface vga_sync_timing_if;
    import vga_timing_pkg::*;

    coord_t  o_X;
    coord_t  o_Y;
    logic    o_Active;
    logic    o_Line_Start;
    logic    o_Frame_Start;
    colour_t i_Red;
    colour_t i_Grn;
    colour_t i_Blu;

    modport master (
        output o_X, o_Y, o_Active,
        output o_Line_Start, o_Frame_Start,
        input  i_Red, i_Grn, i_Blu
    );

    modport slave (
        input  o_X, o_Y, o_Active,
        input  o_Line_Start, o_Frame_Start,
        output i_Red, i_Grn, i_Blu
    );

endinterface

// File: rtl/vga_delay_line.sv
// Clearable shift register; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             i_Clk,
    input  logic             w_Reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ctl;
        assign unused_ctl = ^{i_Clk, w_Reset};
        assign q = d;
    end else begin : g_sr
        logic [WIDTH-1:0] sr [DEPTH];

        always_ff @(posedge i_Clk) begin
            if (w_Reset) begin
                for (int i = 0; i < DEPTH; i++)
                    sr[i] <= '0;
            end else begin
                sr[0] <= d;
                for (int i = 1; i < DEPTH; i++)
                    sr[i] <= sr[i-1];
            end
        end

        assign q = sr[DEPTH-1];
    end

endmodule

// File: rtl/vga_sync_timing.sv
// Raster counters, sync decode and the colour/sync output
// register re-aligned to the downstream colour latency.
module vga_sync_timing
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit SYNC_POL   = 1'b0,
    parameter int PIPE_DELAY = 2
) (
    input  logic               i_Clk,
    input  logic               w_Reset,
    vga_sync_timing_if.master  pix,
    output logic               o_VGA_HSync,
    output logic               o_VGA_VSync,
    output colour_t            o_VGA_Red,
    output colour_t            o_VGA_Grn,
    output colour_t            o_VGA_Blu
);

    localparam int LINE_CLKS =
        H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LINES =
        V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST = coord_t'(LINE_CLKS - 1);
    localparam coord_t V_LAST = coord_t'(FRAME_LINES - 1);
    localparam coord_t H_ACT  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT  = coord_t'(V_ACTIVE);
    localparam coord_t HS_LO  = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_HI  = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_LO  = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_HI  = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    if (LINE_CLKS > 4095 || FRAME_LINES > 4095) begin : g_bad_total
        $error("vga_sync_timing: total exceeds 12-bit counter");
    end

    if (PIPE_DELAY < 0 || PIPE_DELAY > MAX_PIPE) begin : g_bad_pipe
        $error("vga_sync_timing: PIPE_DELAY out of range");
    end

    coord_t h_cnt;
    coord_t v_cnt;

    always_ff @(posedge i_Clk) begin
        if (w_Reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    sync_t raw;
    sync_t dly;

    always_comb begin
        raw        = '0;
        raw.active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        raw.hs     = (h_cnt >= HS_LO) && (h_cnt < HS_HI);
        raw.vs     = (v_cnt >= VS_LO) && (v_cnt < VS_HI);
    end

    assign pix.o_X           = h_cnt;
    assign pix.o_Y           = v_cnt;
    assign pix.o_Active      = raw.active;
    assign pix.o_Line_Start  = (h_cnt == '0);
    assign pix.o_Frame_Start = (h_cnt == '0) && (v_cnt == '0);

    vga_delay_line #(
        .WIDTH ($bits(sync_t)),
        .DEPTH (PIPE_DELAY)
    ) u_dly (
        .i_Clk   (i_Clk),
        .w_Reset (w_Reset),
        .d       (raw),
        .q       (dly)
    );

    // Colour arrives PIPE_DELAY late, so it is sampled here
    // alongside the equally delayed timing flags.
    always_ff @(posedge i_Clk) begin
        if (w_Reset) begin
            o_VGA_HSync <= ~SYNC_POL;
            o_VGA_VSync <= ~SYNC_POL;
            o_VGA_Red   <= '0;
            o_VGA_Grn   <= '0;
            o_VGA_Blu   <= '0;
        end else begin
            o_VGA_HSync <= dly.hs ? SYNC_POL : ~SYNC_POL;
            o_VGA_VSync <= dly.vs ? SYNC_POL : ~SYNC_POL;
            o_VGA_Red   <= dly.active ? pix.i_Red : '0;
            o_VGA_Grn   <= dly.active ? pix.i_Grn : '0;
            o_VGA_Blu   <= dly.active ? pix.i_Blu : '0;
        end
    end

endmodule

// File: tb/tb_vga_sync_timing.sv
// Bench for vga_sync_timing: PIPE_DELAY=2 and PIPE_DELAY=0
// builds, shortened vertical timing, default horizontal.
module tb_vga_sync_timing;
    import vga_timing_pkg::*;

    typedef struct {
        int   x;
        int   y;
        logic act;
        logic ls;
        logic fs;
    } vec_t;

    localparam logic [10:0] IDLE = 11'h600;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #20 clk = ~clk;

    vga_sync_timing_if pix2();
    vga_sync_timing_if pix0();

    logic    hs2, vs2, hs0, vs0;
    colour_t r2, g2, b2, r0, g0, b0;

    vga_sync_timing #(
        .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .PIPE_DELAY(2)
    ) dut2 (
        .i_Clk(clk), .w_Reset(rst), .pix(pix2),
        .o_VGA_HSync(hs2), .o_VGA_VSync(vs2),
        .o_VGA_Red(r2), .o_VGA_Grn(g2), .o_VGA_Blu(b2)
    );

    vga_sync_timing #(
        .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .PIPE_DELAY(0)
    ) dut0 (
        .i_Clk(clk), .w_Reset(rst), .pix(pix0),
        .o_VGA_HSync(hs0), .o_VGA_VSync(vs0),
        .o_VGA_Red(r0), .o_VGA_Grn(g0), .o_VGA_Blu(b0)
    );

    int n_cmp = 0;
    int n_err = 0;
    int mx, my, cyc;
    int last_fs;
    logic [10:0] q2[$];
    logic [10:0] q0[$];
    int h2[$];
    int h0[$];
    vec_t vecs[12];
    bit hit[12];
    bit p_hs2, p_hs0, p_vs2;
    int run_hs2, run_hs0, run_vs2;

    task automatic chk(string nm, logic [31:0] a,
                       logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, a, e);
        end
    endtask

    function automatic logic [8:0] hash(int x, int y);
        logic [11:0] xv;
        logic [11:0] yv;
        xv = 12'(x);
        yv = 12'(y);
        return {xv[2:0], yv[2:0] ^ xv[5:3], xv[8:6]};
    endfunction

    function automatic logic [10:0] exp_pins(int x, int y);
        logic act, hs, vs;
        act = (x < 640) && (y < 4);
        hs  = !((x >= 656) && (x < 752));
        vs  = !((y >= 6) && (y < 8));
        return {hs, vs, act ? hash(x, y) : 9'd0};
    endfunction

    task automatic model_reset();
        mx = 0;
        my = 0;
        q2.delete();
        q0.delete();
        repeat (3) q2.push_back(IDLE);
        q0.push_back(IDLE);
        h2.delete();
        h0.delete();
        p_hs2 = 1'b1; p_hs0 = 1'b1; p_vs2 = 1'b1;
        run_hs2 = 0; run_hs0 = 0; run_vs2 = 0;
        last_fs = -1;
    endtask

    task automatic drive(int c, bit use_hash, bit sel2);
        logic [8:0] col;
        col = use_hash ? hash(c / 4096, c % 4096)
                       : 9'($urandom);
        if (sel2) begin
            pix2.i_Red = col[8:6];
            pix2.i_Grn = col[5:3];
            pix2.i_Blu = col[2:0];
        end else begin
            pix0.i_Red = col[8:6];
            pix0.i_Grn = col[5:3];
            pix0.i_Blu = col[2:0];
        end
    endtask

    task automatic cycle();
        logic act, ls, fs;
        logic [10:0] e;
        int c;
        if (!rst) begin
            act = (mx < 640) && (my < 4);
            ls  = (mx == 0);
            fs  = (mx == 0) && (my == 0);
            chk("xy2", {pix2.o_X, pix2.o_Y}, mx * 4096 + my);
            chk("xy0", {pix0.o_X, pix0.o_Y}, mx * 4096 + my);
            chk("dec2", {pix2.o_Active, pix2.o_Line_Start,
                         pix2.o_Frame_Start}, {act, ls, fs});
            chk("dec0", {pix0.o_Active, pix0.o_Line_Start,
                         pix0.o_Frame_Start}, {act, ls, fs});
            for (int i = 0; i < 12; i++) begin
                if (vecs[i].x == mx && vecs[i].y == my) begin
                    hit[i] = 1'b1;
                    chk($sformatf("vec%0d", i),
                        {pix2.o_Active, pix2.o_Line_Start,
                         pix2.o_Frame_Start},
                        {vecs[i].act, vecs[i].ls, vecs[i].fs});
                end
            end
            e = q2.pop_front();
            chk("pins2", {hs2, vs2, r2, g2, b2}, e);
            q2.push_back(exp_pins(mx, my));
            e = q0.pop_front();
            chk("pins0", {hs0, vs0, r0, g0, b0}, e);
            q0.push_back(exp_pins(mx, my));
            h2.push_back(mx * 4096 + my);
            if (h2.size() > 2) begin
                c = h2.pop_front();
                drive(c, 1'b1, 1'b1);
            end else begin
                drive(0, 1'b0, 1'b1);
            end
            h0.push_back(mx * 4096 + my);
            c = h0.pop_front();
            drive(c, 1'b1, 1'b0);
            if (!hs2) begin
                if (p_hs2) chk("hs2_fall_x", mx, 659);
                run_hs2++;
            end else begin
                if (!p_hs2) chk("hs2_width", run_hs2, 96);
                run_hs2 = 0;
            end
            p_hs2 = hs2;
            if (!hs0) begin
                if (p_hs0) chk("hs0_fall_x", mx, 657);
                run_hs0++;
            end else begin
                if (!p_hs0) chk("hs0_width", run_hs0, 96);
                run_hs0 = 0;
            end
            p_hs0 = hs0;
            if (!vs2) begin
                if (p_vs2)
                    chk("vs2_fall_xy", mx * 4096 + my, 3 * 4096 + 6);
                run_vs2++;
            end else begin
                if (!p_vs2) chk("vs2_width", run_vs2, 1600);
                run_vs2 = 0;
            end
            p_vs2 = vs2;
            if (pix2.o_Frame_Start) begin
                if (last_fs >= 0)
                    chk("frame_period", cyc - last_fs, 8000);
                last_fs = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            model_reset();
        end else if (mx == 799) begin
            mx = 0;
            my = (my == 9) ? 0 : my + 1;
        end else begin
            mx++;
        end
    endtask

    initial begin
        int g;
        vecs[0]  = '{0,   0, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{1,   0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{639, 0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{640, 0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{799, 0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{0,   1, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{639, 3, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{0,   4, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{100, 4, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{0,   9, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{799, 9, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{320, 2, 1'b1, 1'b0, 1'b0};
        foreach (hit[i]) hit[i] = 1'b0;
        cyc = 0;
        pix2.i_Red = '0; pix2.i_Grn = '0; pix2.i_Blu = '0;
        pix0.i_Red = '0; pix0.i_Grn = '0; pix0.i_Blu = '0;
        model_reset();

        repeat (3) cycle();
        chk("rst_xy2", {pix2.o_X, pix2.o_Y}, 0);
        chk("rst_xy0", {pix0.o_X, pix0.o_Y}, 0);
        chk("rst_pins2", {hs2, vs2, r2, g2, b2}, IDLE);
        chk("rst_pins0", {hs0, vs0, r0, g0, b0}, IDLE);
        rst = 1'b0;
        chk("rel_fs", pix2.o_Frame_Start, 1'b1);

        repeat (16050) cycle();

        g = 0;
        while (!(mx == 300 && my == 2) && g < 9000) begin
            cycle();
            g++;
        end
        chk("reach_300_2", mx * 4096 + my, 300 * 4096 + 2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_xy", {pix2.o_X, pix2.o_Y}, 0);
        chk("mid_rst_fs", pix2.o_Frame_Start, 1'b1);
        chk("mid_rst_pins", {hs2, vs2, r2, g2, b2}, IDLE);

        repeat (8050) cycle();

        for (int i = 0; i < 12; i++)
            chk($sformatf("vec%0d_hit", i), hit[i], 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
